hex_keypad_row_debouncer: RTL and testbench



---
 rtl/hex_keypad_pkg.sv | 19 +
 rtl/hex_keypad_row_debouncer_sync_2ff.sv | 23 ++
 rtl/hex_keypad_row_debouncer.sv | 119 +++++++++++
 tb/tb_hex_keypad_row_debouncer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hex_keypad_pkg.sv
// Shared keypad definitions: debouncer state encoding and the all-columns drive value.
package hex_keypad_pkg;

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    typedef enum logic [1:0] {
        RELEASED    = ST_RELEASED,
        PRESS_CHK   = ST_PRESS_CHK,
        PRESSED     = ST_PRESSED,
        RELEASE_CHK = ST_RELEASE_CHK
    } state_t;

    // Column drive that energises every column, so any pressed key shows on Row.
    localparam logic [3:0] COL_ALL = 4'hF;

endpackage

// File: rtl/hex_keypad_row_debouncer_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, synchronously cleared.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p1 <= '0;
            q       <= '0;
        end else begin
            sync_p1 <= d;
            q       <= sync_p1;
        end
    end

endmodule

// File: rtl/hex_keypad_row_debouncer.sv
// Debounces the keypad Row lines and issues one S_Row strobe per accepted press.
module hex_keypad_row_debouncer
    import hex_keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Row_raw,
    input  logic [3:0] Col,
    output logic       S_Row,
    output logic       Pressed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0] row_s;
    logic       col_all;
    logic       col_q2;
    logic       row_any;
    logic       qual;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             strobe_nxt;
    logic             pressed_nxt;

    assign col_all = (Col == COL_ALL);

    // Column qualifier runs through an identical pipe so it lines up with row_s.
    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (Row_raw),
        .q     (row_s)
    );

    sync_2ff #(.WIDTH(1)) u_col_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_all),
        .q     (col_q2)
    );

    assign row_any = |row_s;
    assign qual    = col_q2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RELEASED;
            cnt     <= '0;
            S_Row   <= 1'b0;
            Pressed <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            S_Row   <= strobe_nxt;
            Pressed <= pressed_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        strobe_nxt = 1'b0;
        unique case (state)
            RELEASED: begin
                if (qual && row_any) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PRESS_CHK: begin
                if (qual) begin
                    if (!row_any) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt  = PRESSED;
                        strobe_nxt = 1'b1;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            PRESSED: begin
                if (qual && !row_any) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                if (qual) begin
                    // A row seen again mid-release is still the same press: no strobe.
                    if (row_any) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
    end

endmodule

// File: tb/tb_hex_keypad_row_debouncer.sv
// Bench for hex_keypad_row_debouncer: directed scenarios plus random traffic against a run-length model.
module tb_hex_keypad_row_debouncer;

    localparam int DC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Row_raw = 4'h0;
    logic [3:0] Col = 4'hF;
    logic       S_Row;
    logic       Pressed;

    always #5 clock = ~clock;

    hex_keypad_row_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .Row_raw (Row_raw),
        .Col     (Col),
        .S_Row   (S_Row),
        .Pressed (Pressed)
    );

    int n_chk = 0;
    int n_pass = 0;
    int srow_seen = 0;

    // Model: inputs become visible two edges late; a decision flips after DC
    // consecutive qualified samples that disagree with the current decision.
    logic [3:0] m_rowq[$];
    logic       m_colq[$];
    bit         m_pressed;
    bit         m_strobe;
    int         m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        logic [3:0] r;
        logic       c;
        bit         any;
        if (reset) begin
            m_rowq    = '{4'h0, 4'h0};
            m_colq    = '{1'b0, 1'b0};
            m_pressed = 0;
            m_strobe  = 0;
            m_run     = 0;
            return;
        end
        r = m_rowq.pop_front();
        c = m_colq.pop_front();
        m_rowq.push_back(Row_raw);
        m_colq.push_back(Col == 4'hF);
        m_strobe = 0;
        any = (r != 4'h0);
        if (c) begin
            if (any != m_pressed) begin
                m_run++;
                if (m_run == DC) begin
                    m_pressed = any;
                    m_strobe  = any;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] row, input logic [3:0] col, input logic rst);
        @(negedge clock);
        Row_raw = row;
        Col     = col;
        reset   = rst;
        @(posedge clock);
        model_edge();
        #1;
        chk("S_Row", {31'b0, S_Row}, {31'b0, m_strobe});
        chk("Pressed", {31'b0, Pressed}, {31'b0, m_pressed});
        if (S_Row) srow_seen++;
    endtask

    // Hold Row_raw constant with all columns driven; report first strobe step (1-based) and strobe count.
    task automatic watch(input int n, input logic [3:0] row, output int first, output int cnt);
        int base;
        base  = srow_seen;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            step(row, 4'hF, 1'b0);
            if (S_Row && first < 0) first = i;
        end
        cnt = srow_seen - base;
    endtask

    initial begin
        int first;
        int cnt;
        int base;
        logic [3:0] row;
        logic [3:0] col;
        int len;

        m_rowq = '{4'h0, 4'h0};
        m_colq = '{1'b0, 1'b0};
        m_pressed = 0;
        m_strobe  = 0;
        m_run     = 0;

        repeat (3) step(4'h0, 4'hF, 1'b1);
        chk("rst_srow", {31'b0, S_Row}, 32'd0);
        chk("rst_pressed", {31'b0, Pressed}, 32'd0);
        watch(5, 4'h0, first, cnt);
        chk("idle_cnt", cnt, 32'd0);

        // Clean press: step applied before edge k, strobe after edge k+5.
        watch(60, 4'b0010, first, cnt);
        chk("clean_first", first, 32'd6);
        chk("clean_cnt", cnt, 32'd1);
        chk("clean_held", {31'b0, Pressed}, 32'd1);
        watch(10, 4'h0, first, cnt);
        chk("clean_release", {31'b0, Pressed}, 32'd0);

        // Bounce, then a stable press.
        base = srow_seen;
        for (int i = 0; i < 12; i++)
            step(((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 4'hF, 1'b0);
        chk("bounce_quiet", srow_seen - base, 32'd0);
        chk("bounce_pressed", {31'b0, Pressed}, 32'd0);
        watch(20, 4'b0010, first, cnt);
        chk("bounce_first", first, 32'd6);
        chk("bounce_cnt", cnt, 32'd1);

        // Per-column scanning with no row response must not release.
        base = srow_seen;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                step(4'h0, 4'(1 << c), 1'b0);
        chk("scan_pressed", {31'b0, Pressed}, 32'd1);
        chk("scan_strobe", srow_seen - base, 32'd0);
        watch(10, 4'h0, first, cnt);
        chk("scan_release", {31'b0, Pressed}, 32'd0);

        // Release glitch at cnt=2 of the release check.
        watch(10, 4'b0010, first, cnt);
        chk("glitch_press_first", first, 32'd6);
        base = srow_seen;
        step(4'h0, 4'hF, 1'b0);
        step(4'h0, 4'hF, 1'b0);
        step(4'b1000, 4'hF, 1'b0);
        watch(10, 4'b0010, first, cnt);
        chk("glitch_strobe", srow_seen - base, 32'd0);
        chk("glitch_pressed", {31'b0, Pressed}, 32'd1);

        // Reset in the middle of a press check.
        watch(10, 4'h0, first, cnt);
        repeat (4) step(4'b0010, 4'hF, 1'b0);
        step(4'b0010, 4'hF, 1'b1);
        chk("midrst_srow", {31'b0, S_Row}, 32'd0);
        chk("midrst_pressed", {31'b0, Pressed}, 32'd0);
        watch(20, 4'b0010, first, cnt);
        chk("midrst_first", first, 32'd6);
        chk("midrst_cnt", cnt, 32'd1);

        // Two rows high behave as one key.
        watch(10, 4'h0, first, cnt);
        watch(20, 4'b0101, first, cnt);
        chk("twokey_first", first, 32'd6);
        chk("twokey_cnt", cnt, 32'd1);

        // Random traffic: held row values of random length, occasional scanning and reset.
        for (int i = 0; i < 400; i++) begin
            row = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                col = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                step(row, col, $urandom_range(0, 150) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
